rom_read_arbiter: RTL and testbench
===================================

Name: rom_read_arbiter

Overview:
- Shares the single byte-wide combinational ROM read port between two requesters: port 0 (instruction fetch) and port 1 (data load).
- Sequences one byte read per cycle and assembles 1, 2 or 4 bytes little-endian into a 32-bit response.
- Propagates the ROM's illegal-address flag as a per-response error.
- Sits between the CPU fetch/load units and the ROM memory.

Parameters:
- ADDR_W, 32, address width; matches the ROM read_address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_addr  in  32  port 0 byte address.
- req0_size  in  2  port 0 size: 0 = byte, 1 = half, 2 = word, 3 = reserved.
- req0_ready  out  1  port 0 request accepted this cycle.
- rsp0_valid  out  1  port 0 response valid, one-cycle pulse.
- rsp0_data  out  32  port 0 assembled data, zero-extended.
- rsp0_error  out  1  port 0 response error.
- req1_valid, req1_addr, req1_size, req1_ready, rsp1_valid, rsp1_data, rsp1_error: same as port 0, for port 1.
- rom_read_address  out  32  address driven to the ROM.
- rom_read_data  in  8  ROM byte, combinational from rom_read_address.
- rom_illegal_read_address  in  1  ROM out-of-range flag, combinational.

Behaviour:
- Reset values: state = IDLE, rr_ptr = 0, all ready/rsp_valid/rsp_error = 0, rsp data = 0, rom_read_address = 0, internal data/byte index/error = 0.
- Reset is asynchronous. An asserted reset mid-transaction aborts it; no response is issued.
- States: IDLE, READ, RESP.
- IDLE, arbitration:
  - Grant goes to the only valid port.
  - If both ports are valid, grant goes to the port selected by rr_ptr.
  - reqN_ready = (state == IDLE) && grant == N. It is combinational and asserts for at most one port.
- On an accept edge:
  - Capture base address, nbytes (1/2/4), and owner.
  - Set rr_ptr to the other port. rr_ptr is unchanged when no grant occurs.
  - Clear the data word, byte index and error.
  - Go to READ.
- Reserved size (3):
  - The request is accepted.
  - No ROM reads are performed; go directly to RESP with error = 1 and data = 0.
- READ:
  - rom_read_address = base + idx, computed modulo 2^32 (wraps from 0xFFFFFFFF to 0).
  - On each edge, store rom_read_data into data[8*idx +: 8] and OR rom_illegal_read_address into error.
  - When idx == nbytes-1, go to RESP; otherwise idx + 1.
- RESP:
  - rsp<owner>_valid = 1 for exactly one cycle.
  - rsp_data = data, or 0 if error is set.
  - rsp_error = error.
  - Next state is IDLE. No new grant is made in RESP.
- rsp data/error are registered and held stable until the next response on that port.
- rom_read_address outside READ holds its last value.
- Latency: with the accept edge at cycle T, byte reads occur in cycles T+1 .. T+nbytes and rsp_valid is high in cycle T+nbytes+1.
  - Word: 5 cycles to response.
  - Back-to-back minimum issue interval: nbytes + 2 cycles.
- Requesters must hold valid/addr/size until ready. Deasserting valid before ready is a legal withdrawal.
- Each port has at most one outstanding request. A new request from the owner during READ/RESP simply waits.

Optional Feature:
- Macro ROM_READ_ARBITER_ALIGN_CHECK_EN.
- Defined:
  - Half requests with addr[0] = 1 and word requests with addr[1:0] != 0 are accepted.
  - They skip READ: go straight to RESP with error = 1 and data = 0, with no ROM access.
  - Response arrives in cycle T+1.
- Undefined: misaligned accesses are read byte-wise as normal, with no error.

Test Plan:
- ROM bytes 0x10..0x13 = 11 22 33 44; port 0 word read at 0x10 → ready at T, rom_read_address 0x10..0x13 in T+1..T+4, rsp0_valid at T+5, rsp0_data = 0x44332211, error 0.
- Both ports valid in the same cycle after reset (p0 word @0x0, p1 byte @0x4) → p0 granted first; p1 granted in the IDLE after rsp0; further contention alternates p0/p1/p0.
- depth = 512 (2048 bytes); port 1 word read at 0x7FE → bytes 0x7FE/0x7FF read, 0x800/0x801 illegal → rsp1_error = 1, rsp1_data = 0.
- Port 1 half read at 0x21 with bytes AB CD → rsp1_data = 0x0000CDAB, error 0 when the macro is undefined; with the macro defined → error 1 at T+1, no ROM address change.
- req0_size = 3 → accepted, rsp0_valid at T+1, rsp0_error = 1, rsp0_data = 0.
- Reset asserted in cycle T+2 of a word read → immediately state IDLE, no rsp pulse, all outputs 0; a request issued after reset release completes normally.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// Two-port arbiter for a byte-wide combinational ROM. Assembles 1/2/4-byte little-endian reads, with one response per request after nbytes+1 cycles.
// Round-robin grant in IDLE only, and requesters hold until ready. ROM_READ_ARBITER_ALIGN_CHECK_EN makes misaligned accesses fail fast.
module rom_read_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [1:0]        req0_size,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [31:0]       rsp0_data,
  output logic              rsp0_error,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [1:0]        req1_size,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [31:0]       rsp1_data,
  output logic              rsp1_error,
  output logic [ADDR_W-1:0] rom_read_address,
  input  logic [7:0]        rom_read_data,
  input  logic              rom_illegal_read_address
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        last_idx_q, last_idx_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       rsp0_data_q, rsp0_data_d;
  logic              rsp0_err_q, rsp0_err_d;
  logic [31:0]       rsp1_data_q, rsp1_data_d;
  logic              rsp1_err_q, rsp1_err_d;

  logic              grant_vld;
  logic              grant_port;
  logic [ADDR_W-1:0] gnt_addr;
  logic [1:0]        gnt_size;
  logic              gnt_bad;
  logic [31:0]       rd_word;
  logic              rd_err;
  logic [1:0]        idx_inc;

  always_comb begin
    grant_vld = (state_q == IDLE) && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) begin
      grant_port = rr_ptr_q;
    end else begin
      grant_port = req1_valid;
    end
    gnt_addr = grant_port ? req1_addr : req0_addr;
    gnt_size = grant_port ? req1_size : req0_size;
    gnt_bad  = (gnt_size == 2'd3);
`ifdef ROM_READ_ARBITER_ALIGN_CHECK_EN
    if ((gnt_size == 2'd1 && gnt_addr[0]) ||
        (gnt_size == 2'd2 && gnt_addr[1:0] != 2'b00)) begin
      gnt_bad = 1'b1;
    end
`endif
  end

  assign req0_ready = grant_vld && !grant_port;
  assign req1_ready = grant_vld && grant_port;

  // Word as it will look once the byte currently on the ROM bus is merged in.
  always_comb begin
    rd_word = data_q;
    rd_word[{idx_q, 3'b000} +: 8] = rom_read_data;
    rd_err  = err_q | rom_illegal_read_address;
    idx_inc = idx_q + 2'd1;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    base_d      = base_q;
    last_idx_d  = last_idx_q;
    idx_d       = idx_q;
    data_d      = data_q;
    err_d       = err_q;
    addr_d      = addr_q;
    rsp0_data_d = rsp0_data_q;
    rsp0_err_d  = rsp0_err_q;
    rsp1_data_d = rsp1_data_q;
    rsp1_err_d  = rsp1_err_q;

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          rr_ptr_d = ~grant_port;
          owner_d  = grant_port;
          base_d   = gnt_addr;
          case (gnt_size)
            2'd0:    last_idx_d = 2'd0;
            2'd1:    last_idx_d = 2'd1;
            default: last_idx_d = 2'd3;
          endcase
          idx_d  = 2'd0;
          data_d = 32'd0;
          err_d  = 1'b0;
          if (gnt_bad) begin
            // Rejected sizes/alignments answer immediately without touching the ROM bus.
            err_d   = 1'b1;
            state_d = RESP;
            if (grant_port) begin
              rsp1_data_d = 32'd0;
              rsp1_err_d  = 1'b1;
            end else begin
              rsp0_data_d = 32'd0;
              rsp0_err_d  = 1'b1;
            end
          end else begin
            addr_d  = gnt_addr;
            state_d = READ;
          end
        end
      end
      READ: begin
        data_d = rd_word;
        err_d  = rd_err;
        if (idx_q == last_idx_q) begin
          state_d = RESP;
          if (owner_q) begin
            rsp1_data_d = rd_err ? 32'd0 : rd_word;
            rsp1_err_d  = rd_err;
          end else begin
            rsp0_data_d = rd_err ? 32'd0 : rd_word;
            rsp0_err_d  = rd_err;
          end
        end else begin
          idx_d  = idx_inc;
          addr_d = base_q + ADDR_W'(idx_inc);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      owner_q     <= 1'b0;
      base_q      <= '0;
      last_idx_q  <= 2'd0;
      idx_q       <= 2'd0;
      data_q      <= 32'd0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      rsp0_data_q <= 32'd0;
      rsp0_err_q  <= 1'b0;
      rsp1_data_q <= 32'd0;
      rsp1_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      last_idx_q  <= last_idx_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      rsp0_data_q <= rsp0_data_d;
      rsp0_err_q  <= rsp0_err_d;
      rsp1_data_q <= rsp1_data_d;
      rsp1_err_q  <= rsp1_err_d;
    end
  end

  assign rsp0_valid       = (state_q == RESP) && !owner_q;
  assign rsp1_valid       = (state_q == RESP) && owner_q;
  assign rsp0_data        = rsp0_data_q;
  assign rsp0_error       = rsp0_err_q;
  assign rsp1_data        = rsp1_data_q;
  assign rsp1_error       = rsp1_err_q;
  assign rom_read_address = addr_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed and random stimulus for rom_read_arbiter against a 2048-byte ROM model with a transaction-level reference.
module tb_rom_read_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_addr, req1_addr;
  logic [1:0]  req0_size, req1_size;
  logic        req0_ready, req1_ready;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_error, rsp1_error;
  logic [31:0] rom_read_address;
  logic [7:0]  rom_read_data;
  logic        rom_illegal_read_address;

  logic [7:0]  mem [0:2047];
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  assign rom_illegal_read_address = (rom_read_address >= 32'd2048);
  assign rom_read_data = (rom_read_address < 32'd2048) ? mem[rom_read_address[10:0]] : 8'hEE;

  rom_read_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_size(req0_size), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_error(rsp0_error),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_size(req1_size), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_error(rsp1_error),
    .rom_read_address(rom_read_address), .rom_read_data(rom_read_data),
    .rom_illegal_read_address(rom_illegal_read_address)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what a request should return and how many cycles after accept it arrives.
  task automatic model(input logic [31:0] a, input logic [1:0] s,
                       output logic [31:0] d, output logic e, output int lat);
    int n;
    logic [31:0] ai;
    logic bad;
    n   = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    d   = 32'd0;
    e   = 1'b0;
    bad = (s == 2'd3);
`ifdef ROM_READ_ARBITER_ALIGN_CHECK_EN
    if ((s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00)) bad = 1'b1;
`endif
    if (bad) begin
      e   = 1'b1;
      lat = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        ai = a + 32'(i);
        if (ai >= 32'd2048) e = 1'b1;
        else d = d | (32'(mem[ai[10:0]]) << (8 * i));
      end
      if (e) d = 32'd0;
      lat = n + 1;
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [31:0] a, input logic [1:0] s);
    if (p == 0) begin
      req0_valid = v; req0_addr = a; req0_size = s;
    end else begin
      req1_valid = v; req1_addr = a; req1_size = s;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction
  function automatic logic rspv(input int p);
    return (p == 0) ? rsp0_valid : rsp1_valid;
  endfunction
  function automatic logic [31:0] rspd(input int p);
    return (p == 0) ? rsp0_data : rsp1_data;
  endfunction
  function automatic logic rspe(input int p);
    return (p == 0) ? rsp0_error : rsp1_error;
  endfunction

  // Called just after a negedge with the DUT idle; returns just after the negedge following the response.
  task automatic run_one(input int p, input logic [31:0] a, input logic [1:0] s);
    logic [31:0] ed, prev_addr;
    logic ee;
    int lat, t;
    model(a, s, ed, ee, lat);
    prev_addr = rom_read_address;
    drive(p, 1'b1, a, s);
    #1;
    t = 0;
    while (!rdy(p) && t < 20) begin
      @(negedge clk); #1; t++;
    end
    chk("req_ready", 32'(rdy(p)), 32'd1);
    @(negedge clk);
    drive(p, 1'b0, 32'd0, 2'd0);
    for (int k = 1; k < lat; k++) begin
      chk("rsp_early", 32'(rspv(p)), 32'd0);
      chk("rom_addr", rom_read_address, a + 32'(k - 1));
      @(negedge clk);
    end
    chk("rsp_valid", 32'(rspv(p)), 32'd1);
    chk("rsp_data", rspd(p), ed);
    chk("rsp_error", 32'(rspe(p)), 32'(ee));
    if (lat == 1) chk("rom_addr_hold", rom_read_address, prev_addr);
    @(negedge clk);
    chk("rsp_pulse", 32'(rspv(p)), 32'd0);
    chk("rsp_data_hold", rspd(p), ed);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra [2];
    logic [1:0]  rs [2];
    logic [31:0] ed;
    logic ee;
    int lat, t, exp_w, pulses;

    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;
    mem[33] = 8'hAB; mem[34] = 8'hCD;
    reset = 1'b1;
    drive(0, 1'b0, 32'd0, 2'd0);
    drive(1, 1'b0, 32'd0, 2'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp0_data", rsp0_data, 32'd0);
    chk("rst_rsp1_data", rsp1_data, 32'd0);
    chk("rst_rsp0_error", 32'(rsp0_error), 32'd0);
    chk("rst_rsp1_error", 32'(rsp1_error), 32'd0);
    chk("rst_rom_addr", rom_read_address, 32'd0);

    // Contention from reset: p0 first, then strict alternation.
    ra[0] = 32'h0; rs[0] = 2'd2;
    ra[1] = 32'h4; rs[1] = 2'd0;
    drive(0, 1'b1, ra[0], rs[0]);
    drive(1, 1'b1, ra[1], rs[1]);
    exp_w = 0;
    for (int rnd = 0; rnd < 6; rnd++) begin
      #1;
      t = 0;
      while (!(req0_ready || req1_ready) && t < 20) begin
        @(negedge clk); #1; t++;
      end
      chk("arb_one_hot", 32'(req0_ready & req1_ready), 32'd0);
      chk("arb_winner", 32'(req1_ready), 32'(exp_w));
      model(ra[exp_w], rs[exp_w], ed, ee, lat);
      @(negedge clk);
      if (rnd < 5) begin
        ra[exp_w] = 32'($urandom_range(0, 2100));
        rs[exp_w] = 2'($urandom_range(0, 3));
        drive(exp_w, 1'b1, ra[exp_w], rs[exp_w]);
      end else begin
        drive(exp_w, 1'b0, 32'd0, 2'd0);
      end
      t = 1;
      while (!rspv(exp_w) && t < 20) begin
        @(negedge clk); t++;
      end
      chk("arb_latency", 32'(t), 32'(lat));
      chk("arb_data", rspd(exp_w), ed);
      chk("arb_error", 32'(rspe(exp_w)), 32'(ee));
      if (rnd == 5) begin
        drive(0, 1'b0, 32'd0, 2'd0);
        drive(1, 1'b0, 32'd0, 2'd0);
      end
      @(negedge clk);
      exp_w = 1 - exp_w;
    end

    run_one(0, 32'h10, 2'd2);
    chk("word_0x10", rsp0_data, 32'h44332211);
    run_one(1, 32'h7FE, 2'd2);
    run_one(1, 32'h21, 2'd1);
    run_one(0, 32'h10, 2'd3);
    run_one(0, 32'hFFFF_FFFE, 2'd2);
    run_one(1, 32'h7FF, 2'd0);
    run_one(1, 32'h800, 2'd0);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 2060));
      run_one(int'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)));
    end

    // Make sure the held response registers are non-zero before the abort.
    run_one(0, 32'h10, 2'd2);
    run_one(1, 32'h21, 2'd0);
    drive(0, 1'b1, 32'h10, 2'd2);
    #1;
    chk("abort_ready", 32'(req0_ready), 32'd1);
    @(negedge clk);
    drive(0, 1'b0, 32'd0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("abort_rsp0_data", rsp0_data, 32'd0);
    chk("abort_rsp0_error", 32'(rsp0_error), 32'd0);
    chk("abort_rsp1_data", rsp1_data, 32'd0);
    chk("abort_rom_addr", rom_read_address, 32'd0);
    chk("abort_ready0", 32'(req0_ready), 32'd0);
    pulses = 0;
    repeat (2) begin
      @(negedge clk); pulses += int'(rsp0_valid) + int'(rsp1_valid);
    end
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk); pulses += int'(rsp0_valid) + int'(rsp1_valid);
    end
    chk("abort_no_rsp", 32'(pulses), 32'd0);
    run_one(0, 32'h10, 2'd2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
